// File: rtl/rotate_sweep_ctrl_if.sv
// Bus between the sweep sequencer and the external combinational barrel shifter.
// master = sequencer side, slave = shifter side.
interface rotate_sweep_ctrl_if;
  logic [7:0] sh_a;
  logic [2:0] sh_amt;
  logic       sh_lr;
  logic [7:0] sh_y;

  modport master (output sh_a, output sh_amt, output sh_lr, input sh_y);
  modport slave  (input sh_a, input sh_amt, input sh_lr, output sh_y);
endinterface

// File: rtl/rotate_sweep_ctrl.sv
// Rotate/sweep sequencer: feeds q through an external barrel shifter on every
// prescaled tick, either rotating one way or ping-ponging every SWEEP_LEN steps.
//
// state | meaning
// IDLE  | waiting for start, q holds last value
// RUN_L | stepping, shifter rotates left
// RUN_R | stepping, shifter rotates right
module rotate_sweep_ctrl #(
  parameter int TICK_DIV  = 4,
  parameter int SWEEP_LEN = 7
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start_i,
  input  logic                       stop_i,
  input  logic [7:0]                 pattern_i,
  input  logic [2:0]                 step_amt_i,
  input  logic                       dir_init_i,
  input  logic                       bounce_i,
  input  logic [7:0]                 n_steps_i,
  rotate_sweep_ctrl_if.master        sh,
  output logic [7:0]                 q_o,
  output logic                       busy_o,
  output logic                       step_strobe_o,
  output logic                       done_o
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, RUN_L, RUN_R} state_e;

  state_e         state_q, state_d;
  logic [7:0]     q_q, q_d;
  logic [2:0]     amt_q, amt_d;
  logic           bounce_q, bounce_d;
  logic [7:0]     nsteps_q, nsteps_d;
  logic [TW-1:0]  tick_q, tick_d;
  logic [7:0]     dir_cnt_q, dir_cnt_d;
  logic [7:0]     step_cnt_q, step_cnt_d;
  logic           strobe_q, strobe_d;
  logic           done_q, done_d;

  logic           tick;
  logic [7:0]     step_inc;
  logic [7:0]     dir_inc;

  assign tick     = (tick_q == TW'(TICK_DIV - 1));
  assign step_inc = step_cnt_q + 8'd1;
  assign dir_inc  = dir_cnt_q + 8'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      q_q        <= '0;
      amt_q      <= '0;
      bounce_q   <= 1'b0;
      nsteps_q   <= '0;
      tick_q     <= '0;
      dir_cnt_q  <= '0;
      step_cnt_q <= '0;
      strobe_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      q_q        <= q_d;
      amt_q      <= amt_d;
      bounce_q   <= bounce_d;
      nsteps_q   <= nsteps_d;
      tick_q     <= tick_d;
      dir_cnt_q  <= dir_cnt_d;
      step_cnt_q <= step_cnt_d;
      strobe_q   <= strobe_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    q_d        = q_q;
    amt_d      = amt_q;
    bounce_d   = bounce_q;
    nsteps_d   = nsteps_q;
    tick_d     = tick_q;
    dir_cnt_d  = dir_cnt_q;
    step_cnt_d = step_cnt_q;
    strobe_d   = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i && !stop_i) begin
          q_d        = pattern_i;
          amt_d      = step_amt_i;
          bounce_d   = bounce_i;
          nsteps_d   = n_steps_i;
          tick_d     = '0;
          dir_cnt_d  = '0;
          step_cnt_d = '0;
          state_d    = dir_init_i ? RUN_R : RUN_L;
        end
      end
      RUN_L, RUN_R: begin
        if (stop_i) begin
          state_d = IDLE;
        end else begin
          tick_d = tick ? '0 : tick_q + TW'(1);
          if (tick) begin
            q_d        = sh.sh_y;
            strobe_d   = 1'b1;
            step_cnt_d = step_inc;
            dir_cnt_d  = dir_inc;
            if (bounce_q && dir_inc == 8'(SWEEP_LEN)) begin
              dir_cnt_d = '0;
              state_d   = (state_q == RUN_L) ? RUN_R : RUN_L;
            end
            // completion overrides a coincident reversal
            if (nsteps_q != 8'd0 && step_inc == nsteps_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sh.sh_a        = q_q;
  assign sh.sh_amt      = amt_q;
  assign sh.sh_lr       = (state_q == RUN_R);
  assign q_o            = q_q;
  assign busy_o         = (state_q != IDLE);
  assign step_strobe_o  = strobe_q;
  assign done_o         = done_q;

endmodule

// File: tb/tb_rotate_sweep_ctrl.sv
// Self-checking bench for rotate_sweep_ctrl against a step-indexed reference model.
module tb_rotate_sweep_ctrl;
  localparam int TD = 4;
  localparam int SL = 7;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start, stop, dir_init, bounce;
  logic [7:0] pattern, n_steps;
  logic [2:0] step_amt;
  logic [7:0] q;
  logic       busy, step_strobe, done;
  int         checks = 0;
  int         errors = 0;

  rotate_sweep_ctrl_if sh_bus ();

  rotate_sweep_ctrl #(.TICK_DIV(TD), .SWEEP_LEN(SL)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start_i       (start),
    .stop_i        (stop),
    .pattern_i     (pattern),
    .step_amt_i    (step_amt),
    .dir_init_i    (dir_init),
    .bounce_i      (bounce),
    .n_steps_i     (n_steps),
    .sh            (sh_bus.slave),
    .q_o           (q),
    .busy_o        (busy),
    .step_strobe_o (step_strobe),
    .done_o        (done)
  );

  always #5 clk = ~clk;

  // External shifter: rotate one bit at a time
  always_comb begin
    logic [7:0] v;
    v = sh_bus.sh_a;
    for (int i = 0; i < 7; i++) begin
      if (i < int'(sh_bus.sh_amt))
        v = sh_bus.sh_lr ? {v[0], v[7:1]} : {v[6:0], v[7]};
    end
    sh_bus.sh_y = v;
  end

  function automatic logic [7:0] rot(input logic [7:0] v, input int a, input logic right);
    logic [15:0] t;
    t = {v, v};
    if (right) begin
      t = t >> a;
      return t[7:0];
    end
    t = t << a;
    return t[15:8];
  endfunction

  // direction of 1-based step k
  function automatic logic dir_of(input int k, input logic d0, input logic b);
    if (!b) return d0;
    return d0 ^ (((k - 1) / SL) % 2 == 1);
  endfunction

  task automatic scramble_inputs();
    pattern  = 8'($urandom);
    step_amt = 3'($urandom);
    dir_init = 1'($urandom);
    bounce   = 1'($urandom);
    n_steps  = 8'($urandom);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start = 0; stop = 0; dir_init = 0; bounce = 0;
    pattern = 0; n_steps = 0; step_amt = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({q, sh_bus.sh_a, sh_bus.sh_amt, sh_bus.sh_lr, busy, step_strobe, done} !== 23'd0) begin
      errors++;
      $display("FAIL reset_outputs got q=%h a=%h amt=%0d lr=%b busy=%b stb=%b done=%b want all 0",
               q, sh_bus.sh_a, sh_bus.sh_amt, sh_bus.sh_lr, busy, step_strobe, done);
    end
    @(negedge clk) reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || q !== 8'd0) begin
      errors++;
      $display("FAIL reset_idle got busy=%b q=%h want 0 00", busy, q);
    end
  endtask

  // Start a run, then compare every cycle against the step-indexed model.
  task automatic run_seq(input string name, input logic [7:0] pat, input logic [2:0] amt,
                         input logic d0, input logic b, input logic [7:0] n,
                         input int cycles, input int restart_at);
    logic [7:0] qexp[$];
    int steps, last_steps;
    logic busy_e, stb_e, done_e, lr_e;
    qexp.push_back(pat);
    for (int k = 1; k <= cycles / TD + 1; k++)
      qexp.push_back(rot(qexp[k-1], int'(amt), dir_of(k, d0, b)));

    @(negedge clk);
    start = 1; stop = 0; pattern = pat; step_amt = amt; dir_init = d0; bounce = b; n_steps = n;
    @(posedge clk);
    #1 start = 0;
    scramble_inputs();
    @(negedge clk);
    checks++;
    if (q !== pat || busy !== 1'b1 || sh_bus.sh_lr !== d0 || sh_bus.sh_amt !== amt || step_strobe !== 1'b0) begin
      errors++;
      $display("FAIL %s_accept got q=%h busy=%b lr=%b amt=%0d stb=%b want q=%h busy=1 lr=%b amt=%0d stb=0",
               name, q, busy, sh_bus.sh_lr, sh_bus.sh_amt, step_strobe, pat, d0, amt);
    end
    last_steps = 0;
    for (int j = 1; j <= cycles; j++) begin
      if (j == restart_at) scramble_inputs();
      start = (j == restart_at);
      @(posedge clk);
      #1 start = 0;
      @(negedge clk);
      busy_e = !(n != 0 && j >= int'(n) * TD);
      steps  = busy_e ? j / TD : int'(n);
      stb_e  = (j % TD == 0) && (n == 0 || j <= int'(n) * TD);
      done_e = (n != 0) && (j == int'(n) * TD);
      lr_e   = busy_e ? dir_of(steps + 1, d0, b) : 1'b0;
      last_steps = steps;
      checks++;
      if (q !== qexp[steps] || sh_bus.sh_a !== qexp[steps]) begin
        errors++;
        $display("FAIL %s_q cyc=%0d got q=%h a=%h want %h", name, j, q, sh_bus.sh_a, qexp[steps]);
      end
      checks++;
      if (step_strobe !== stb_e || done !== done_e) begin
        errors++;
        $display("FAIL %s_pulse cyc=%0d got stb=%b done=%b want stb=%b done=%b",
                 name, j, step_strobe, done, stb_e, done_e);
      end
      checks++;
      if (busy !== busy_e || sh_bus.sh_lr !== lr_e) begin
        errors++;
        $display("FAIL %s_state cyc=%0d got busy=%b lr=%b want busy=%b lr=%b",
                 name, j, busy, sh_bus.sh_lr, busy_e, lr_e);
      end
    end
    stop = 1;
    @(posedge clk);
    #1 stop = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || q !== qexp[last_steps] || done !== 1'b0) begin
      errors++;
      $display("FAIL %s_stop got busy=%b q=%h done=%b want busy=0 q=%h done=0",
               name, busy, q, done, qexp[last_steps]);
    end
  endtask

  task automatic test_rotate();
    run_seq("rotate", 8'h01, 3'd1, 1'b0, 1'b0, 8'd0, 40 * TD, -1);
  endtask

  task automatic test_bounce();
    run_seq("bounce", 8'h01, 3'd1, 1'b0, 1'b1, 8'd0, 3 * SL * TD + 2 * TD, -1);
  endtask

  task automatic test_nsteps();
    run_seq("nsteps", 8'h81, 3'd2, 1'b1, 1'b0, 8'd3, 3 * TD + 3, -1);
    checks++;
    if (q !== 8'h06) begin
      errors++;
      $display("FAIL nsteps_final got q=%h want 06", q);
    end
    // completion on the same tick as a reversal, with zero rotation
    run_seq("amt0_rev_done", 8'hC3, 3'd0, 1'b0, 1'b1, 8'(SL), SL * TD + 4, -1);
  endtask

  task automatic test_back_to_back();
    run_seq("busy_start", 8'h33, 3'd1, 1'b0, 1'b0, 8'd5, 5 * TD + 2, 6);
    run_seq("busy_start_b", 8'h0F, 3'd3, 1'b1, 1'b1, 8'd0, 4 * TD, TD);
  endtask

  task automatic test_stop();
    @(negedge clk);
    start = 1; stop = 0; pattern = 8'h01; step_amt = 3'd1; dir_init = 0; bounce = 0; n_steps = 0;
    @(posedge clk);
    #1 start = 0;
    repeat (2 * TD - 1) @(posedge clk);
    @(negedge clk) stop = 1;
    @(posedge clk);
    #1 stop = 0;
    @(negedge clk);
    checks++;
    if (q !== 8'h02 || step_strobe !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stop_on_tick got q=%h stb=%b done=%b busy=%b want 02 0 0 0",
               q, step_strobe, done, busy);
    end
    start = 1; stop = 1; pattern = 8'hAA;
    @(posedge clk);
    #1 begin start = 0; stop = 0; end
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || q !== 8'h02) begin
      errors++;
      $display("FAIL start_with_stop got busy=%b q=%h want 0 02", busy, q);
    end
  endtask

  task automatic test_reset_midrun();
    @(negedge clk);
    start = 1; pattern = 8'h5A; step_amt = 3'd3; dir_init = 1; bounce = 1; n_steps = 0;
    @(posedge clk);
    #1 start = 0;
    repeat (2 * TD) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if ({q, sh_bus.sh_a, sh_bus.sh_amt, sh_bus.sh_lr, busy, step_strobe, done} !== 23'd0) begin
      errors++;
      $display("FAIL reset_midrun got q=%h a=%h amt=%0d lr=%b busy=%b stb=%b done=%b want all 0",
               q, sh_bus.sh_a, sh_bus.sh_amt, sh_bus.sh_lr, busy, step_strobe, done);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3 * TD) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || q !== 8'd0 || step_strobe !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got busy=%b q=%h stb=%b done=%b want 0 00 0 0",
               busy, q, step_strobe, done);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      logic [7:0] pat, n;
      logic [2:0] amt;
      logic d0, b;
      int cyc, rs;
      pat = 8'($urandom);
      amt = 3'($urandom);
      d0  = 1'($urandom);
      b   = 1'($urandom);
      n   = 8'($urandom_range(0, 20));
      cyc = (n != 0) ? int'(n) * TD + int'($urandom_range(0, 6)) : int'($urandom_range(10, 80));
      rs  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, (n != 0) ? int'(n) * TD - 1 : cyc)) : -1;
      run_seq("random", pat, amt, d0, b, n, cyc, rs);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rotate();
    test_bounce();
    test_nsteps();
    test_stop();
    test_back_to_back();
    test_reset_midrun();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
